// File: rtl/rcu_rst_seq.sv
// Multi-channel reset sequencer: releases CHN_NUM domains in index order with per-channel delays.
// Optional stall timeout enabled by defining RCU_RST_SEQ_TIMEOUT_EN (adds TMO_CYC and tmo_o).
module rcu_rst_seq #(
    parameter int CHN_NUM    = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int SYNC_STAGE = 2,
    parameter int SW_PULSE   = 8
`ifdef RCU_RST_SEQ_TIMEOUT_EN
    ,
    parameter int TMO_CYC    = 1024
`endif
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         ext_rst_i,
    input  logic [CHN_NUM-1:0]           sw_rst_req_i,
    input  logic [CHN_NUM*CNT_WIDTH-1:0] dly_i,
    input  logic [CHN_NUM-1:0]           hold_i,
    output logic [CHN_NUM-1:0]           chn_rst_o,
    output logic                         seq_busy_o,
    output logic                         seq_done_o,
    output logic [1:0]                   rst_cause_o
`ifdef RCU_RST_SEQ_TIMEOUT_EN
    ,
    output logic                         tmo_o
`endif
);

    localparam int IDX_W = (CHN_NUM > 1) ? $clog2(CHN_NUM) : 1;
`ifdef RCU_RST_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                 state_r, state_s;
    logic [SYNC_STAGE-1:0]  ext_sync_r;
    logic                   ext_sync_s;
    logic [CNT_WIDTH-1:0]   dly_sh_r [CHN_NUM];
    logic [CNT_WIDTH-1:0]   dly_sh_s [CHN_NUM];
    logic [CNT_WIDTH-1:0]   sw_cnt_r [CHN_NUM];
    logic [CNT_WIDTH-1:0]   sw_cnt_s [CHN_NUM];
    logic [IDX_W-1:0]       idx_r, idx_s;
    logic [CNT_WIDTH-1:0]   cnt_r, cnt_s, dly_nxt_s;
    logic [CHN_NUM-1:0]     seq_rst_r, seq_rst_s, sw_mask_s;
    logic [1:0]             cause_s;
    logic                   hold_cur_s, force_s;
`ifdef RCU_RST_SEQ_TIMEOUT_EN
    logic [TMO_W-1:0]       stall_r, stall_s;
    logic                   tmo_s;
`endif

    assign ext_sync_s = ext_sync_r[SYNC_STAGE-1];

    // Next-state, counter and output computation; external reset outranks everything else
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        cnt_s      = cnt_r;
        seq_rst_s  = seq_rst_r;
        cause_s    = rst_cause_o;
        hold_cur_s = 1'b0;
        dly_nxt_s  = {CNT_WIDTH{1'b0}};
        sw_mask_s  = {CHN_NUM{1'b0}};
`ifdef RCU_RST_SEQ_TIMEOUT_EN
        stall_s    = stall_r;
        tmo_s      = tmo_o;
        force_s    = 1'b0;
`else
        force_s    = 1'b0;
`endif
        for (int k = 0; k < CHN_NUM; k++) begin
            dly_sh_s[k] = dly_sh_r[k];
            sw_cnt_s[k] = (sw_cnt_r[k] != {CNT_WIDTH{1'b0}}) ? sw_cnt_r[k] - 1'b1 : sw_cnt_r[k];
            if (idx_r == IDX_W'(k)) begin
                hold_cur_s = hold_i[k];
            end else begin
                hold_cur_s = hold_cur_s;
            end
            if (int'(idx_r) + 1 == k) begin
                dly_nxt_s = dly_sh_r[k];
            end else begin
                dly_nxt_s = dly_nxt_s;
            end
        end
`ifdef RCU_RST_SEQ_TIMEOUT_EN
        force_s = hold_cur_s && (stall_r == TMO_W'(TMO_CYC));
`endif

        if (ext_sync_s) begin
            state_s   = ASSERT;
            seq_rst_s = {CHN_NUM{1'b1}};
            cause_s   = 2'b10;
            for (int k = 0; k < CHN_NUM; k++) begin
                sw_cnt_s[k] = {CNT_WIDTH{1'b0}};
            end
`ifdef RCU_RST_SEQ_TIMEOUT_EN
            stall_s = {TMO_W{1'b0}};
            tmo_s   = 1'b0;
`endif
        end else begin
            case (state_r)
                ASSERT: begin
                    seq_rst_s = {CHN_NUM{1'b1}};
                    for (int k = 0; k < CHN_NUM; k++) begin
                        dly_sh_s[k] = dly_i[k*CNT_WIDTH +: CNT_WIDTH];
                    end
                    idx_s   = {IDX_W{1'b0}};
                    cnt_s   = dly_i[CNT_WIDTH-1:0];
                    state_s = RELEASE;
                end
                RELEASE: begin
                    if (cnt_r != {CNT_WIDTH{1'b0}}) begin
                        cnt_s = cnt_r - 1'b1;
                    end else if (!hold_cur_s || force_s) begin
                        for (int k = 0; k < CHN_NUM; k++) begin
                            if (idx_r == IDX_W'(k)) begin
                                seq_rst_s[k] = 1'b0;
                            end else begin
                                seq_rst_s[k] = seq_rst_s[k];
                            end
                        end
                        if (idx_r == IDX_W'(CHN_NUM - 1)) begin
                            state_s = DONE;
                        end else begin
                            idx_s = idx_r + 1'b1;
                            cnt_s = dly_nxt_s;
                        end
`ifdef RCU_RST_SEQ_TIMEOUT_EN
                        stall_s = {TMO_W{1'b0}};
                        if (force_s) begin
                            tmo_s = 1'b1;
                        end else begin
                            tmo_s = tmo_o;
                        end
`endif
                    end else begin
`ifdef RCU_RST_SEQ_TIMEOUT_EN
                        stall_s = stall_r + 1'b1;
`endif
                        state_s = RELEASE;
                    end
                end
                DONE: begin
                    state_s = IDLE;
                end
                IDLE: begin
                    for (int k = 0; k < CHN_NUM; k++) begin
                        if (sw_rst_req_i[k]) begin
                            sw_cnt_s[k] = CNT_WIDTH'(SW_PULSE);
                        end else begin
                            sw_cnt_s[k] = sw_cnt_s[k];
                        end
                    end
                    if (|sw_rst_req_i) begin
                        cause_s = 2'b11;
                    end else begin
                        cause_s = rst_cause_o;
                    end
                end
                default: begin
                    state_s = ASSERT;
                end
            endcase
        end

        for (int k = 0; k < CHN_NUM; k++) begin
            sw_mask_s[k] = (sw_cnt_s[k] != {CNT_WIDTH{1'b0}});
        end
    end

    // State, shadow, counters and registered outputs; reset holds every domain in reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ASSERT;
            ext_sync_r  <= {SYNC_STAGE{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            cnt_r       <= {CNT_WIDTH{1'b0}};
            seq_rst_r   <= {CHN_NUM{1'b1}};
            chn_rst_o   <= {CHN_NUM{1'b1}};
            seq_busy_o  <= 1'b1;
            seq_done_o  <= 1'b0;
            rst_cause_o <= 2'b01;
            for (int k = 0; k < CHN_NUM; k++) begin
                dly_sh_r[k] <= {CNT_WIDTH{1'b0}};
                sw_cnt_r[k] <= {CNT_WIDTH{1'b0}};
            end
`ifdef RCU_RST_SEQ_TIMEOUT_EN
            stall_r     <= {TMO_W{1'b0}};
            tmo_o       <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            ext_sync_r  <= {ext_sync_r[SYNC_STAGE-2:0], ext_rst_i};
            idx_r       <= idx_s;
            cnt_r       <= cnt_s;
            seq_rst_r   <= seq_rst_s;
            chn_rst_o   <= seq_rst_s | sw_mask_s;
            seq_busy_o  <= (state_s != IDLE);
            seq_done_o  <= (state_s == DONE);
            rst_cause_o <= cause_s;
            for (int k = 0; k < CHN_NUM; k++) begin
                dly_sh_r[k] <= dly_sh_s[k];
                sw_cnt_r[k] <= sw_cnt_s[k];
            end
`ifdef RCU_RST_SEQ_TIMEOUT_EN
            stall_r     <= stall_s;
            tmo_o       <= tmo_s;
`endif
        end
    end

endmodule

// File: tb/tb_rcu_rst_seq.sv
// Directed self-checking bench for rcu_rst_seq (CHN_NUM=4, CNT_WIDTH=8, SYNC_STAGE=2, SW_PULSE=8).
module tb_rcu_rst_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        ext_rst;
    logic [3:0]  sw_req;
    logic [31:0] dly;
    logic [3:0]  hold;
    logic [3:0]  chn_rst;
    logic        busy;
    logic        done;
    logic [1:0]  cause;
`ifdef RCU_RST_SEQ_TIMEOUT_EN
    logic        tmo;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef RCU_RST_SEQ_TIMEOUT_EN
    rcu_rst_seq #(.CHN_NUM(4), .CNT_WIDTH(8), .SYNC_STAGE(2), .SW_PULSE(8), .TMO_CYC(16)) dut (
`else
    rcu_rst_seq #(.CHN_NUM(4), .CNT_WIDTH(8), .SYNC_STAGE(2), .SW_PULSE(8)) dut (
`endif
        .clk_i        (clk),
        .rst_i        (rst),
        .ext_rst_i    (ext_rst),
        .sw_rst_req_i (sw_req),
        .dly_i        (dly),
        .hold_i       (hold),
        .chn_rst_o    (chn_rst),
        .seq_busy_o   (busy),
        .seq_done_o   (done),
        .rst_cause_o  (cause)
`ifdef RCU_RST_SEQ_TIMEOUT_EN
        ,
        .tmo_o        (tmo)
`endif
    );

    // Apply reset with the given delays/holds; returns just before edge 1
    task automatic do_por(input logic [31:0] d, input logic [3:0] h);
        rst = 1'b1; ext_rst = 1'b0; sw_req = 4'b0000; dly = d; hold = h;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; ext_rst = 1'b0; sw_req = 4'b0000; dly = 32'd0; hold = 4'b0000;
        #12;
        checks++;
        if (chn_rst !== 4'b1111 || busy !== 1'b1 || done !== 1'b0 || cause !== 2'b01) begin
            errors++;
            $display("FAIL reset_values got chn=%b busy=%b done=%b cause=%b exp chn=1111 busy=1 done=0 cause=01",
                     chn_rst, busy, done, cause);
        end
    endtask

    // dly={2,0,3,1}: releases at edges 4,5,9,11, done after edge 11
    task automatic test_por;
        int rel[4] = '{4, 5, 9, 11};
        logic [3:0] exp;
        do_por({8'd1, 8'd3, 8'd0, 8'd2}, 4'b0000);
        for (int e = 1; e <= 12; e++) begin
            run_edges(1);
            for (int k = 0; k < 4; k++) exp[k] = (e < rel[k]);
            checks++;
            if (chn_rst !== exp) begin
                errors++;
                $display("FAIL por_chn edge=%0d got=%b exp=%b", e, chn_rst, exp);
            end
            checks++;
            if (done !== (e == 11) || busy !== (e < 12) || cause !== 2'b01) begin
                errors++;
                $display("FAIL por_status edge=%0d got done=%b busy=%b cause=%b exp done=%b busy=%b cause=01",
                         e, done, busy, cause, (e == 11), (e < 12));
            end
        end
    endtask

    task automatic test_sw_pulse;
        logic [3:0] exp;
        do_por(32'd0, 4'b0000);
        run_edges(7);
        sw_req = 4'b0101;
        for (int e = 1; e <= 10; e++) begin
            run_edges(1);
            sw_req = 4'b0000;
            exp = (e <= 8) ? 4'b0101 : 4'b0000;
            checks++;
            if (chn_rst !== exp || busy !== 1'b0 || cause !== 2'b11) begin
                errors++;
                $display("FAIL sw_pulse edge=%0d got chn=%b busy=%b cause=%b exp chn=%b busy=0 cause=11",
                         e, chn_rst, busy, cause, exp);
            end
        end
    endtask

    // ch0 requested at edge 1 and again at 6, ch1 at edge 4
    task automatic test_sw_overlap;
        logic [3:0] exp;
        do_por(32'd0, 4'b0000);
        run_edges(7);
        for (int e = 1; e <= 15; e++) begin
            sw_req = (e == 1 || e == 6) ? 4'b0001 : ((e == 4) ? 4'b0010 : 4'b0000);
            run_edges(1);
            sw_req = 4'b0000;
            exp = {2'b00, (e >= 4 && e < 12), (e >= 1 && e < 14)};
            checks++;
            if (chn_rst !== exp) begin
                errors++;
                $display("FAIL sw_overlap edge=%0d got=%b exp=%b", e, chn_rst, exp);
            end
        end
    endtask

    task automatic test_release_ignore;
        int rel[4] = '{4, 5, 9, 11};
        logic [3:0] exp;
        do_por({8'd1, 8'd3, 8'd0, 8'd2}, 4'b0000);
        for (int e = 1; e <= 12; e++) begin
            sw_req = (e == 2 || e == 6) ? 4'b1111 : 4'b0000;
            if (e == 2) dly = 32'hFFFF_FFFF;
            run_edges(1);
            sw_req = 4'b0000;
            for (int k = 0; k < 4; k++) exp[k] = (e < rel[k]);
            checks++;
            if (chn_rst !== exp || cause !== 2'b01) begin
                errors++;
                $display("FAIL release_ignore edge=%0d got chn=%b cause=%b exp chn=%b cause=01",
                         e, chn_rst, cause, exp);
            end
        end
    endtask

    // dly={2,5,3,1}: POR releases at 4,10,14,16; ext raised after edge 6, restart offset 11
    task automatic test_ext_restart;
        int rel[4] = '{4, 10, 14, 16};
        logic [3:0] exp;
        do_por({8'd1, 8'd3, 8'd5, 8'd2}, 4'b0000);
        run_edges(6);
        ext_rst = 1'b1;
        for (int e = 7; e <= 28; e++) begin
            run_edges(1);
            if (e < 9) exp = 4'b1110;
            else for (int k = 0; k < 4; k++) exp[k] = (e < 11 + rel[k]);
            checks++;
            if (chn_rst !== exp || cause !== ((e < 9) ? 2'b01 : 2'b10) || done !== (e == 27)) begin
                errors++;
                $display("FAIL ext_restart edge=%0d got chn=%b cause=%b done=%b exp chn=%b cause=%b done=%b",
                         e, chn_rst, cause, done, exp, ((e < 9) ? 2'b01 : 2'b10), (e == 27));
            end
            if (e == 9) ext_rst = 1'b0;
        end
    endtask

    // hold ch2 until after edge 20: releases at 4,5,21,23
    task automatic test_hold;
        int rel[4] = '{4, 5, 21, 23};
        logic [3:0] exp;
        do_por({8'd1, 8'd3, 8'd0, 8'd2}, 4'b0100);
        for (int e = 1; e <= 24; e++) begin
            run_edges(1);
            for (int k = 0; k < 4; k++) exp[k] = (e < rel[k]);
            checks++;
            if (chn_rst !== exp || done !== (e == 23) || busy !== (e < 24)) begin
                errors++;
                $display("FAIL hold edge=%0d got chn=%b done=%b busy=%b exp chn=%b done=%b busy=%b",
                         e, chn_rst, done, busy, exp, (e == 23), (e < 24));
            end
            if (e == 20) hold = 4'b0000;
        end
    endtask

    task automatic test_rst_mid;
        do_por({8'd1, 8'd3, 8'd5, 8'd2}, 4'b0000);
        run_edges(6);
        checks++;
        if (chn_rst !== 4'b1110) begin
            errors++;
            $display("FAIL rst_mid_pre got=%b exp=1110", chn_rst);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (chn_rst !== 4'b1111 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async got chn=%b busy=%b done=%b exp chn=1111 busy=1 done=0",
                     chn_rst, busy, done);
        end
    endtask

`ifdef RCU_RST_SEQ_TIMEOUT_EN
    // hold ch1: stalls edges 5..20, force release at 21, ch2 at 25, ch3 at 27
    task automatic test_timeout;
        int rel[4] = '{4, 21, 25, 27};
        logic [3:0] exp;
        do_por({8'd1, 8'd3, 8'd0, 8'd2}, 4'b0010);
        for (int e = 1; e <= 28; e++) begin
            run_edges(1);
            for (int k = 0; k < 4; k++) exp[k] = (e < rel[k]);
            checks++;
            if (chn_rst !== exp || tmo !== (e >= 21)) begin
                errors++;
                $display("FAIL timeout edge=%0d got chn=%b tmo=%b exp chn=%b tmo=%b",
                         e, chn_rst, tmo, exp, (e >= 21));
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (tmo !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear got=%b exp=0", tmo);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_por;
        test_sw_pulse;
        test_sw_overlap;
        test_release_ignore;
        test_ext_restart;
        test_hold;
        test_rst_mid;
`ifdef RCU_RST_SEQ_TIMEOUT_EN
        test_timeout;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
